// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler for the RV32I register file. It arbitrates the single
// write port between the ALU and load paths and keeps the busy scoreboard used for issue stalls.
module rf_wb_scheduler #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    output logic            iss_stall,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    output logic            rf_en,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_write,
    output logic [NREG-1:0] busy
);

    // alu_prio_q=1 means the ALU wins the next contended cycle.
    logic            alu_prio_q, alu_prio_d;
    logic            rf_en_q, rf_en_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_write_q, rf_write_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic            grant_alu, grant_ld, xfer, iss_fire, stall;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;

    always_comb begin
        grant_alu = alu_valid && (!ld_valid || alu_prio_q);
        grant_ld  = ld_valid && !grant_alu;
        xfer      = grant_alu || grant_ld;
        win_rd    = grant_alu ? alu_rd : ld_rd;
        win_data  = grant_alu ? alu_data : ld_data;
        // Registered busy only: a writeback this cycle releases the stall next cycle.
        stall     = iss_valid && (busy_q[iss_rs1] || busy_q[iss_rs2] || busy_q[iss_rd]);
        iss_fire  = iss_valid && !stall && (iss_rd != 5'd0);
    end

    always_comb begin
        alu_prio_d = alu_prio_q;
        rf_en_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_write_d = rf_write_q;
        busy_d     = busy_q;

        if (alu_valid && ld_valid) begin
            alu_prio_d = !grant_alu;
        end

        if (xfer && (win_rd != 5'd0)) begin
            rf_en_d    = 1'b1;
            rf_rd_d    = win_rd;
            rf_write_d = win_data;
        end

        // Clear first so a coincident set on the same register wins.
        for (int i = 1; i < NREG; i++) begin
            if (xfer && (win_rd == i[4:0])) begin
                busy_d[i] = 1'b0;
            end
            if (iss_fire && (iss_rd == i[4:0])) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_prio_q <= 1'b1;
            rf_en_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_write_q <= '0;
            busy_q     <= '0;
        end else begin
            alu_prio_q <= alu_prio_d;
            rf_en_q    <= rf_en_d;
            rf_rd_q    <= rf_rd_d;
            rf_write_q <= rf_write_d;
            busy_q     <= busy_d;
        end
    end

    assign alu_ready = grant_alu;
    assign ld_ready  = grant_ld;
    assign iss_stall = stall;
    assign rf_en     = rf_en_q;
    assign rf_rd     = rf_rd_q;
    assign rf_write  = rf_write_q;
    assign busy      = busy_q;

endmodule
